// File: rtl/serv_bufreg2_seq_pkg.sv
// Shared types and constants for the serv_bufreg2 sequencer.
package serv_bufreg2_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MEM  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [1:0] CMD_SHIFT = 2'b00;
  localparam logic [1:0] CMD_STORE = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [4:0] CNT_LAST = 5'd31;

  // Number of bytes covered by an access size; 1x encodings are words.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    if (size == SIZE_BYTE) begin
      return 3'd1;
    end else if (size == SIZE_HALF) begin
      return 3'd2;
    end else begin
      return 3'd4;
    end
  endfunction

endpackage

// File: rtl/serv_bufreg2_seq_bytesel.sv
// byte_valid decode for serv_bufreg2: loads mask bytes beyond the access size.
module serv_bufreg2_seq_bytesel
  import serv_bufreg2_seq_pkg::*;
(
  input  logic [1:0] cnt_hi_i,
  input  logic [1:0] size_i,
  input  logic [1:0] op_i,
  output logic       byte_valid_o
);

  always_comb begin
    byte_valid_o = 1'b1;
    if (op_i == CMD_LOAD) begin
      byte_valid_o = ({1'b0, cnt_hi_i} < size_nbytes(size_i));
    end
  end

endmodule

// File: rtl/serv_bufreg2_seq.sv
// Command sequencer driving serv_bufreg2 through INIT / MEM / 32-cycle RUN.
// Optional memory-wait timeout: define SERV_BUFREG2_SEQ_TIMEOUT_EN.
module serv_bufreg2_seq
  import serv_bufreg2_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [1:0] i_cmd_lsb,
  input  logic [1:0] i_cmd_size,
  input  logic       i_cmd_op_b_sel,
  output logic       o_mem_req,
  input  logic       i_mem_ack,
  input  logic       i_sh_done,
  output logic       o_en,
  output logic       o_init,
  output logic       o_cnt_done,
  output logic       o_byte_valid,
  output logic       o_load,
  output logic       o_op_b_sel,
  output logic       o_shift_op,
  output logic [1:0] o_lsb,
  output logic [4:0] o_cnt,
  output logic       o_done,
  output logic       o_err
);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] lsb_q, lsb_d;
  logic [1:0] size_q, size_d;
  logic       opb_q, opb_d;
  logic [4:0] cnt_q, cnt_d;
  logic       bv_raw;

`ifdef SERV_BUFREG2_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 tmo_hit;

  // Fires on the MEM cycle whose increment would make the counter all-ones.
  assign tmo_hit = (tmo_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

  always_comb begin
    tmo_d = '0;
    err_d = 1'b0;
    if (state_q == S_MEM) begin
      tmo_d = tmo_q + TIMEOUT_W'(1);
      err_d = !i_mem_ack && tmo_hit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lsb_d   = lsb_q;
    size_d  = size_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          op_d   = i_cmd_op;
          lsb_d  = i_cmd_lsb;
          size_d = i_cmd_size;
          opb_d  = i_cmd_op_b_sel;
          case (i_cmd_op)
            CMD_SHIFT, CMD_STORE: state_d = S_INIT;
            CMD_LOAD:             state_d = S_MEM;
            default:              state_d = S_DONE;
          endcase
        end
      end
      S_INIT: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q == CMD_SHIFT) begin
          if (i_sh_done || cnt_q == CNT_LAST) state_d = S_RUN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (i_mem_ack) begin
          state_d = (op_q == CMD_LOAD) ? S_RUN : S_DONE;
        end
`ifdef SERV_BUFREG2_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_IDLE;
        end
`endif
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Every phase starts counting from zero, including an early SHIFT exit.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      lsb_q   <= '0;
      size_q  <= '0;
      opb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lsb_q   <= lsb_d;
      size_q  <= size_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
    end
  end

  serv_bufreg2_seq_bytesel u_bytesel (
    .cnt_hi_i     (cnt_q[4:3]),
    .size_i       (size_q),
    .op_i         (op_q),
    .byte_valid_o (bv_raw)
  );

  assign o_cmd_ready  = (state_q == S_IDLE);
  assign o_en         = (state_q == S_INIT) || (state_q == S_RUN);
  assign o_init       = (state_q == S_INIT);
  assign o_shift_op   = (state_q == S_INIT) && (op_q == CMD_SHIFT);
  assign o_cnt_done   = (state_q == S_RUN) && (cnt_q == CNT_LAST);
  assign o_byte_valid = o_en && bv_raw;
  assign o_mem_req    = (state_q == S_MEM);
  assign o_load       = (state_q == S_MEM) && i_mem_ack && (op_q == CMD_LOAD);
  assign o_done       = (state_q == S_DONE);
  assign o_op_b_sel   = opb_q;
  assign o_lsb        = lsb_q;
  assign o_cnt        = cnt_q;

endmodule

// File: tb/tb_serv_bufreg2_seq.sv
// Randomized bench for serv_bufreg2_seq against a phase-level timeline model.
module tb_serv_bufreg2_seq;

  logic       clk = 1'b0;
  logic       i_rst_n, i_cmd_valid, i_cmd_op_b_sel, i_mem_ack, i_sh_done;
  logic [1:0] i_cmd_op, i_cmd_lsb, i_cmd_size;
  logic       o_cmd_ready, o_mem_req, o_en, o_init, o_cnt_done, o_byte_valid;
  logic       o_load, o_op_b_sel, o_shift_op, o_done, o_err;
  logic [1:0] o_lsb;
  logic [4:0] o_cnt;

  always #5 clk = ~clk;

  serv_bufreg2_seq #(.TIMEOUT_W(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_lsb(i_cmd_lsb), .i_cmd_size(i_cmd_size),
    .i_cmd_op_b_sel(i_cmd_op_b_sel),
    .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack), .i_sh_done(i_sh_done),
    .o_en(o_en), .o_init(o_init), .o_cnt_done(o_cnt_done),
    .o_byte_valid(o_byte_valid), .o_load(o_load), .o_op_b_sel(o_op_b_sel),
    .o_shift_op(o_shift_op), .o_lsb(o_lsb), .o_cnt(o_cnt),
    .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [1:0]  op, lsb, size;
    logic        opb, ack, shd;
    logic [17:0] outs;
  } cyc_t;

  typedef struct {
    logic [1:0] op, lsb, size;
    logic       opb;
    int         k;      // INIT cycle (1-based) carrying sh_done; 0 or >32 = never
    int         tmem;   // MEM cycles until ack; 0 = never ack
    int         gap;
    bit         hold;   // offer the next command during this one's busy period
    int         rst_at; // RUN count at which reset is pulsed; -1 = none
  } cmd_t;

  cyc_t tl[$];
  cmd_t cmds[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic       d_rst_n, d_valid, d_opb;
  logic [1:0] d_op, d_lsb, d_size;
  logic [1:0] m_lsb;
  logic       m_opb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic ready, en, init, cdone, bv, load, shop, req, done, err,
                      input logic [4:0] cnt, input logic ack, shd);
    cyc_t c;
    c.rst_n = d_rst_n; c.valid = d_valid; c.op = d_op; c.lsb = d_lsb;
    c.size = d_size; c.opb = d_opb; c.ack = ack; c.shd = shd;
    c.outs = {ready, en, init, cdone, bv, load, shop, m_opb, req, done, err, m_lsb, cnt};
    tl.push_back(c);
  endtask

  task automatic build(input cmd_t c, input cmd_t nx, input bit has_nx);
    int tinit;
    int nb;
    d_rst_n = 1'b1;
    d_valid = 1'b0;
    repeat (c.gap) push(1,0,0,0,0,0,0,0,0,0, 5'd0, rb(), rb());
    d_valid = 1'b1; d_op = c.op; d_lsb = c.lsb; d_size = c.size; d_opb = c.opb;
    push(1,0,0,0,0,0,0,0,0,0, 5'd0, rb(), rb());
    m_lsb = c.lsb;
    m_opb = c.opb;
    if (c.hold && has_nx) begin
      d_op = nx.op; d_lsb = nx.lsb; d_size = nx.size; d_opb = nx.opb;
    end else begin
      d_valid = 1'b0;
    end
    nb = (c.size == 2'd0) ? 1 : (c.size == 2'd1) ? 2 : 4;
    if (c.op == 2'd0) begin
      tinit = (c.k >= 1 && c.k <= 32) ? c.k : 32;
      for (int i = 0; i < tinit; i++)
        push(0,1,1,0,1,0,1,0,0,0, 5'(i), rb(), logic'(i == c.k - 1));
    end else if (c.op == 2'd1) begin
      for (int i = 0; i < 32; i++)
        push(0,1,1,0,1,0,0,0,0,0, 5'(i), rb(), rb());
    end
    if (c.op == 2'd1 || c.op == 2'd2) begin
      if (c.tmem == 0) begin
        for (int j = 0; j < 255; j++) push(0,0,0,0,0,0,0,1,0,0, 5'd0, 1'b0, rb());
        d_valid = 1'b0;
        push(1,0,0,0,0,0,0,0,0,1, 5'd0, rb(), rb());
        return;
      end
      for (int j = 0; j < c.tmem; j++)
        push(0,0,0,0,0, logic'(c.op == 2'd2 && j == c.tmem - 1), 0,1,0,0, 5'd0,
             logic'(j == c.tmem - 1), rb());
    end
    if (c.op == 2'd0 || c.op == 2'd2) begin
      for (int i = 0; i < 32; i++) begin
        if (c.rst_at == i) begin
          d_rst_n = 1'b0;
          push(0,1,0,0,1,0,0,0,0,0, 5'(i), rb(), rb());
          d_rst_n = 1'b1;
          d_valid = 1'b0;
          m_lsb = 2'd0;
          m_opb = 1'b0;
          push(1,0,0,0,0,0,0,0,0,0, 5'd0, rb(), rb());
          return;
        end
        push(0,1,0, logic'(i == 31),
             (c.op == 2'd2) ? logic'((i / 8) < nb) : 1'b1,
             0,0,0,0,0, 5'(i), rb(), rb());
      end
    end
    push(0,0,0,0,0,0,0,0,1,0, 5'd0, rb(), rb());
  endtask

  function automatic cmd_t mk(input logic [1:0] op, lsb, size, input logic opb,
                              input int k, tmem, gap, input bit hold, input int rst_at);
    cmd_t c;
    c.op = op; c.lsb = lsb; c.size = size; c.opb = opb; c.k = k; c.tmem = tmem;
    c.gap = gap; c.hold = hold; c.rst_at = rst_at;
    return c;
  endfunction

  initial begin
    cyc_t  cy;
    cmd_t  dummy;
    logic [17:0] got;

    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_lsb = '0;
    i_cmd_size = '0; i_cmd_op_b_sel = 1'b0; i_mem_ack = 1'b0; i_sh_done = 1'b0;
    m_lsb = 2'd0; m_opb = 1'b0;
    d_rst_n = 1'b1; d_valid = 1'b0; d_op = '0; d_lsb = '0; d_size = '0; d_opb = 1'b0;

    cmds.push_back(mk(2'd0, 2'd1, 2'd0, 1'b0,  6, 1, 1, 0, -1)); // shift, done on 6th INIT
    cmds.push_back(mk(2'd0, 2'd3, 2'd2, 1'b1,  0, 1, 0, 0, -1)); // shift, sh_done never
    cmds.push_back(mk(2'd0, 2'd0, 2'd1, 1'b1,  1, 1, 2, 0, -1)); // shift by zero
    cmds.push_back(mk(2'd2, 2'd2, 2'd0, 1'b0,  0, 3, 1, 0, -1)); // load byte, lsb 2
    cmds.push_back(mk(2'd1, 2'd1, 2'd2, 1'b1,  0, 2, 1, 1, -1)); // store word, next held
    cmds.push_back(mk(2'd2, 2'd0, 2'd1, 1'b1,  0, 1, 0, 0, -1)); // load half, back-to-back
    cmds.push_back(mk(2'd3, 2'd2, 2'd0, 1'b1,  0, 1, 1, 0, -1)); // reserved op
    for (int n = 0; n < 25; n++)
      cmds.push_back(mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), rb(), $urandom_range(0, 36),
                        $urandom_range(1, 6), $urandom_range(0, 2),
                        ($urandom_range(0, 2) == 0), -1));
    cmds.push_back(mk(2'd0, 2'd3, 2'd0, 1'b1,  3, 1, 1, 0, 12)); // reset mid-RUN
`ifdef SERV_BUFREG2_SEQ_TIMEOUT_EN
    cmds.push_back(mk(2'd2, 2'd1, 2'd2, 1'b1,  0, 0, 1, 0, -1)); // no ack: timeout
`endif
    cmds.push_back(mk(2'd2, 2'd1, 2'd2, 1'b0,  0, 2, 1, 0, -1));

    dummy = cmds[0];
    foreach (cmds[i]) begin
      if (i + 1 < cmds.size()) build(cmds[i], cmds[i+1], 1'b1);
      else build(cmds[i], dummy, 1'b0);
    end
    d_valid = 1'b0;
    push(1,0,0,0,0,0,0,0,0,0, 5'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    foreach (tl[i]) begin
      cy = tl[i];
      i_rst_n = cy.rst_n; i_cmd_valid = cy.valid; i_cmd_op = cy.op;
      i_cmd_lsb = cy.lsb; i_cmd_size = cy.size; i_cmd_op_b_sel = cy.opb;
      i_mem_ack = cy.ack; i_sh_done = cy.shd;
      #1;
      got = {o_cmd_ready, o_en, o_init, o_cnt_done, o_byte_valid, o_load, o_shift_op,
             o_op_b_sel, o_mem_req, o_done, o_err, o_lsb, o_cnt};
      check_eq($sformatf("cyc%0d{rdy,en,init,cdone,bv,load,shop,opb,req,done,err,lsb,cnt}", i),
               {14'd0, got}, {14'd0, cy.outs});
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
